fft_r2_iter: RTL and testbench

Iterative, parametrised radix-2 decimation-in-frequency FFT core operating on packed complex fixed-point words {re, im}. It accepts N samples over a valid/ready stream and computes the transform in place with one shared butterfly, one butterfly per cycle. It then streams the N bins out in natural order. It is the sequential, size-generic successor to the team's fully combinational 8-point DIF network and adds per-stage scaling and flow control.

---
 rtl/fft_r2_iter.sv | 170 +++++++++++++++++
 tb/tb_fft_r2_iter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_r2_iter.sv
// Iterative radix-2 DIF FFT: N-entry in-place register array, one shared butterfly per cycle,
// bins streamed out in natural order over valid/ready.
module fft_r2_iter #(
  parameter int unsigned W     = 16,
  parameter int unsigned FRAC  = 8,
  parameter int unsigned LOG2N = 3,
  parameter int unsigned SCALE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*W-1:0]   in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_data,
  output logic [LOG2N-1:0] out_index,
  output logic             out_last,
  output logic             busy
);
  localparam int unsigned N  = 1 << LOG2N;
  localparam int unsigned SW = $clog2(LOG2N);

  typedef enum logic [1:0] {StLoad, StCompute, StUnload} state_e;

  state_e           state_q;
  logic [2*W-1:0]   mem_q [N];
  logic [LOG2N-1:0] cnt_q;
  logic [LOG2N-1:0] bfly_q;
  logic [SW-1:0]    stage_q;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    for (int i = 0; i < LOG2N; i++) bitrev[i] = v[LOG2N-1-i];
  endfunction

  assign in_ready = (state_q == StLoad) && !rst;

  // Butterfly addressing and twiddle selection
  logic [LOG2N-1:0] span_mask, top, bot, tw_t;
  logic [2:0]       tw_idx;
  int               tw_re_i, tw_im_i;
  logic signed [W-1:0] tw_re, tw_im;

  always_comb begin
    span_mask = LOG2N'((N >> (stage_q + 1)) - 1);
    top       = ((bfly_q & ~span_mask) << 1) | (bfly_q & span_mask);
    bot       = top + span_mask + LOG2N'(1);
    tw_t      = (bfly_q & span_mask) << stage_q;
    // ROM holds W_16^t; an 8-point transform uses every other entry
    tw_idx    = 3'(tw_t << (4 - LOG2N));
    tw_re_i   = 256;
    tw_im_i   = 0;
    unique case (tw_idx)
      3'd0: begin tw_re_i = 256;  tw_im_i = 0;    end
      3'd1: begin tw_re_i = 237;  tw_im_i = -98;  end
      3'd2: begin tw_re_i = 181;  tw_im_i = -181; end
      3'd3: begin tw_re_i = 98;   tw_im_i = -237; end
      3'd4: begin tw_re_i = 0;    tw_im_i = -256; end
      3'd5: begin tw_re_i = -98;  tw_im_i = -237; end
      3'd6: begin tw_re_i = -181; tw_im_i = -181; end
      3'd7: begin tw_re_i = -237; tw_im_i = -98;  end
      default: ;
    endcase
    tw_re = W'(tw_re_i <<< (FRAC - 8));
    tw_im = W'(tw_im_i <<< (FRAC - 8));
  end

  logic [2*W-1:0]        a_word, b_word;
  logic signed [W-1:0]   a_re, a_im, b_re, b_im;
  logic signed [W:0]     s_re, s_im, d_re, d_im;
  logic signed [W-1:0]   sum_re, sum_im, dif_re, dif_im;
  logic signed [2*W-1:0] p_rr, p_ii, p_ri, p_ir;
  logic [W-1:0]          m_re, m_im;

  always_comb begin
    a_word = mem_q[top];
    b_word = mem_q[bot];
    a_re   = a_word[2*W-1:W];
    a_im   = a_word[W-1:0];
    b_re   = b_word[2*W-1:W];
    b_im   = b_word[W-1:0];
    s_re   = {a_re[W-1], a_re} + {b_re[W-1], b_re};
    s_im   = {a_im[W-1], a_im} + {b_im[W-1], b_im};
    d_re   = {a_re[W-1], a_re} - {b_re[W-1], b_re};
    d_im   = {a_im[W-1], a_im} - {b_im[W-1], b_im};
    sum_re = (SCALE != 0) ? s_re[W:1] : s_re[W-1:0];
    sum_im = (SCALE != 0) ? s_im[W:1] : s_im[W-1:0];
    dif_re = (SCALE != 0) ? d_re[W:1] : d_re[W-1:0];
    dif_im = (SCALE != 0) ? d_im[W:1] : d_im[W-1:0];
    p_rr   = (2*W)'(dif_re) * (2*W)'(tw_re);
    p_ii   = (2*W)'(dif_im) * (2*W)'(tw_im);
    p_ri   = (2*W)'(dif_re) * (2*W)'(tw_im);
    p_ir   = (2*W)'(dif_im) * (2*W)'(tw_re);
    m_re   = p_rr[FRAC+W-1:FRAC] - p_ii[FRAC+W-1:FRAC];
    m_im   = p_ri[FRAC+W-1:FRAC] + p_ir[FRAC+W-1:FRAC];
  end

  logic unused_bits;
  assign unused_bits = ^{s_re[W], s_re[0], s_im[W], s_im[0], d_re[W], d_re[0], d_im[W], d_im[0],
                         p_rr[2*W-1:FRAC+W], p_rr[FRAC-1:0], p_ii[2*W-1:FRAC+W], p_ii[FRAC-1:0],
                         p_ri[2*W-1:FRAC+W], p_ri[FRAC-1:0], p_ir[2*W-1:FRAC+W], p_ir[FRAC-1:0]};

  logic [LOG2N-1:0] nxt_k;
  assign nxt_k = out_index + LOG2N'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StLoad;
      cnt_q     <= '0;
      bfly_q    <= '0;
      stage_q   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (in_valid) begin
            mem_q[cnt_q] <= in_data;
            cnt_q        <= cnt_q + LOG2N'(1);
            if (cnt_q == LOG2N'(N - 1)) begin
              state_q <= StCompute;
              busy    <= 1'b1;
            end
          end
        end
        StCompute: begin
          mem_q[top] <= {sum_re, sum_im};
          mem_q[bot] <= {m_re, m_im};
          if (bfly_q == LOG2N'(N/2 - 1)) begin
            bfly_q <= '0;
            if (stage_q == SW'(LOG2N - 1)) begin
              stage_q   <= '0;
              state_q   <= StUnload;
              out_valid <= 1'b1;
              out_index <= '0;
              out_last  <= 1'b0;
              // Bin 0 lives in entry 0, which the final butterfly (entries N-2, N-1) never touches
              out_data  <= mem_q[0];
            end else begin
              stage_q <= stage_q + SW'(1);
            end
          end else begin
            bfly_q <= bfly_q + LOG2N'(1);
          end
        end
        StUnload: begin
          if (out_ready) begin
            if (out_last) begin
              state_q   <= StLoad;
              out_valid <= 1'b0;
              out_data  <= '0;
              out_index <= '0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
            end else begin
              out_index <= nxt_k;
              out_data  <= mem_q[bitrev(nxt_k)];
              out_last  <= (nxt_k == LOG2N'(N - 1));
            end
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_r2_iter.sv
// Self-checking bench for fft_r2_iter: three instances (N=8, N=8 scaled, N=16) checked against
// a reference DIF model plus hand-computed bin values.
module tb_fft_r2_iter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [31:0] in_data;
  logic [31:0] out_data [3];
  logic [2:0]  oidx0, oidx1;
  logic [3:0]  oidx2;
  logic [3:0]  out_index [3];

  assign out_index[0] = {1'b0, oidx0};
  assign out_index[1] = {1'b0, oidx1};
  assign out_index[2] = oidx2;

  fft_r2_iter #(.W(16), .FRAC(8), .LOG2N(3), .SCALE(0)) u_n8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .out_index(oidx0), .out_last(out_last[0]), .busy(busy[0]));

  fft_r2_iter #(.W(16), .FRAC(8), .LOG2N(3), .SCALE(1)) u_n8s (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .out_index(oidx1), .out_last(out_last[1]), .busy(busy[1]));

  fft_r2_iter #(.W(16), .FRAC(8), .LOG2N(4), .SCALE(0)) u_n16 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
    .out_index(oidx2), .out_last(out_last[2]), .busy(busy[2]));

  int vectors = 0;
  int errors  = 0;

  int tw_re_t [8] = '{256, 237, 181, 98, 0, -98, -181, -237};
  int tw_im_t [8] = '{0, -98, -181, -237, -256, -237, -181, -98};

  logic [31:0] frame [16];
  logic [31:0] exp_bins [3][16];
  logic [31:0] captured [3][16];
  int          launched [3] = '{0, 0, 0};
  int          done [3]     = '{0, 0, 0};
  int          exp_k [3]    = '{0, 0, 0};
  bit          pend_ready [3] = '{0, 0, 0};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  function automatic int npts(input int id);
    return (id == 2) ? 16 : 8;
  endfunction

  function automatic int brev(input int v, input int lg);
    int r = 0;
    for (int i = 0; i < lg; i++) if (((v >> i) & 1) != 0) r |= 1 << (lg - 1 - i);
    return r;
  endfunction

  function automatic int wrap16(input int v);
    return (v <<< 16) >>> 16;
  endfunction

  // Reference transform: textbook in-place DIF on integers, then bit-reversed read-out
  task automatic load_model(input int id);
    int lg, n, sc, span, top, bot, ti, sr, si, dr, di, c, d, b;
    int re [16];
    int im [16];
    lg = (id == 2) ? 4 : 3;
    n  = 1 << lg;
    sc = (id == 1) ? 1 : 0;
    for (int i = 0; i < n; i++) begin
      re[i] = int'($signed(frame[i][31:16]));
      im[i] = int'($signed(frame[i][15:0]));
    end
    for (int s = 0; s < lg; s++) begin
      span = n >> (s + 1);
      for (int j = 0; j < n / 2; j++) begin
        top = (j / span) * 2 * span + (j % span);
        bot = top + span;
        ti  = ((j % span) << s) * (16 / n);
        sr = re[top] + re[bot];  si = im[top] + im[bot];
        dr = re[top] - re[bot];  di = im[top] - im[bot];
        if (sc != 0) begin
          sr = sr >>> 1;  si = si >>> 1;  dr = dr >>> 1;  di = di >>> 1;
        end
        re[top] = wrap16(sr);  im[top] = wrap16(si);
        dr = wrap16(dr);  di = wrap16(di);
        c = tw_re_t[ti];  d = tw_im_t[ti];
        re[bot] = wrap16(((dr * c) >>> 8) - ((di * d) >>> 8));
        im[bot] = wrap16(((dr * d) >>> 8) + ((di * c) >>> 8));
      end
    end
    for (int k = 0; k < n; k++) begin
      b = brev(k, lg);
      exp_bins[id][k] = {re[b][15:0], im[b][15:0]};
    end
  endtask

  // Output compare: every cycle a bin is presented it must be the next expected bin
  always @(negedge clk) begin
    int k;
    if (!rst) begin
      for (int id = 0; id < 3; id++) begin
        if (pend_ready[id]) begin
          check($sformatf("ready_after_last[%0d]", id), {in_ready[id], busy[id], out_valid[id]},
                32'b100);
          pend_ready[id] = 1'b0;
        end
        if (busy[id]) check($sformatf("in_ready_busy[%0d]", id), 32'(in_ready[id]), 32'd0);
        if (out_valid[id]) begin
          if (launched[id] == done[id]) begin
            check($sformatf("unexpected_valid[%0d]", id), 32'(out_valid[id]), 32'd0);
          end else begin
            k = exp_k[id];
            check($sformatf("index[%0d]", id), 32'(out_index[id]), 32'(k));
            check($sformatf("bin[%0d][%0d]", id, k), out_data[id], exp_bins[id][k]);
            check($sformatf("last[%0d][%0d]", id, k), 32'(out_last[id]),
                  32'(k == npts(id) - 1));
            if (out_ready[id]) begin
              captured[id][k] = out_data[id];
              if (k == npts(id) - 1) begin
                exp_k[id] = 0;
                done[id]++;
                pend_ready[id] = 1'b1;
              end else begin
                exp_k[id] = k + 1;
              end
            end
          end
        end
      end
    end
  end

  task automatic send_frame(input int id, input bit gaps);
    int  i = 0;
    int  guard = 0;
    bit  odd = 1'b0;
    bit  acc;
    while (i < npts(id) && guard < 200) begin
      in_valid[id] = !(gaps && odd);
      in_data      = frame[i];
      @(negedge clk);
      acc = in_valid[id] && in_ready[id];
      @(posedge clk);
      #1;
      if (acc) i++;
      odd = !odd;
      guard++;
    end
    in_valid[id] = 1'b0;
    if (guard >= 200) check("load_timeout", 32'(i), 32'(npts(id)));
    check($sformatf("compute_start[%0d]", id), {busy[id], in_ready[id]}, 32'b10);
  endtask

  task automatic wait_valid(input int id);
    int c = 0;
    while (!out_valid[id] && c < 100) begin
      @(posedge clk);
      #1;
      c++;
    end
    check($sformatf("latency[%0d]", id), 32'(c), (id == 2) ? 32'd32 : 32'd12);
  endtask

  task automatic drain(input int id, input bit bp);
    int c = 0;
    while (done[id] != launched[id] && c < 400) begin
      out_ready[id] = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      #1;
      c++;
    end
    out_ready[id] = 1'b0;
    if (c >= 400) check("drain_timeout", 32'(done[id]), 32'(launched[id]));
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int id, input bit gaps, input bit bp, input bit noise);
    load_model(id);
    launched[id]++;
    send_frame(id, gaps);
    if (noise) begin
      in_valid[id] = 1'b1;
      in_data      = 32'hDEAD_BEEF;
    end
    wait_valid(id);
    in_valid[id] = 1'b0;
    drain(id, bp);
  endtask

  task automatic set_impulse();
    for (int i = 0; i < 16; i++) frame[i] = 32'h0;
    frame[0] = 32'h0100_0000;
  endtask

  initial begin
    int re, im, er;
    rst = 1'b1;
    in_valid = '0;
    out_ready = '0;
    in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int id = 0; id < 3; id++) begin
      check($sformatf("rst_outs[%0d]", id),
            {27'(out_index[id]), out_valid[id], out_last[id], busy[id], in_ready[id]}, 32'h0);
      check($sformatf("rst_data[%0d]", id), out_data[id], 32'h0);
    end
    rst = 1'b0;
    #1;
    for (int id = 0; id < 3; id++) check($sformatf("ready_after_rst[%0d]", id),
                                         32'(in_ready[id]), 32'd1);

    // Impulse, N=8 unscaled
    set_impulse();
    run_frame(0, 1'b0, 1'b0, 1'b0);
    check("model_impulse_x0", exp_bins[0][0], 32'h0100_0000);
    check("model_impulse_x5", exp_bins[0][5], 32'h0100_0000);

    // DC, unscaled and scaled
    for (int i = 0; i < 16; i++) frame[i] = 32'h0100_0000;
    run_frame(0, 1'b0, 1'b0, 1'b0);
    check("model_dc_x0", exp_bins[0][0], 32'h0800_0000);
    check("model_dc_x3", exp_bins[0][3], 32'h0);
    run_frame(1, 1'b0, 1'b1, 1'b0);
    check("model_dcs_x0", exp_bins[1][0], 32'h0100_0000);
    check("model_dcs_x6", exp_bins[1][6], 32'h0);

    // Tone at bin 1, N=16
    for (int n = 0; n < 16; n++)
      frame[n] = {16'((n < 8) ? tw_re_t[n] : -tw_re_t[n-8]), 16'h0};
    run_frame(2, 1'b0, 1'b1, 1'b0);
    check("model_tone_x1", exp_bins[2][1], 32'h0800_FFFD);
    check("model_tone_x15", exp_bins[2][15], 32'h0801_0000);
    for (int k = 0; k < 16; k++) begin
      re = int'($signed(captured[2][k][31:16]));
      im = int'($signed(captured[2][k][15:0]));
      er = (k == 1 || k == 15) ? 2048 : 0;
      vectors++;
      if (re < er - 4 || re > er + 4 || im < -4 || im > 4) begin
        errors++;
        $display("FAIL tone_bin%0d: got re=%0d im=%0d, required re=%0d+-4 im=0+-4",
                 k, re, im, er);
      end
    end

    // Backpressure with a wrapping frame; in_valid held high during COMPUTE
    frame[0] = 32'h0040_0010;  frame[1] = 32'hFFC0_0020;
    frame[2] = 32'h0100_FF00;  frame[3] = 32'h0000_0080;
    frame[4] = 32'h7F00_0000;  frame[5] = 32'h8100_0100;
    frame[6] = 32'h0033_FFCC;  frame[7] = 32'h0005_0005;
    run_frame(0, 1'b0, 1'b1, 1'b1);

    // Reset at COMPUTE cycle 5: no output, then a clean frame
    set_impulse();
    send_frame(0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("ready_after_mid_rst", {in_ready[0], busy[0], out_valid[0]}, 32'b100);
    repeat (20) @(posedge clk);
    #1;
    check("no_valid_after_rst", 32'(out_valid[0]), 32'd0);
    run_frame(0, 1'b0, 1'b0, 1'b0);

    // Input gaps on alternate cycles
    run_frame(0, 1'b1, 1'b0, 1'b0);
    check("model_gap_x7", exp_bins[0][7], 32'h0100_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
